// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - request/result bundle between EX stage, controller and divider
//
// Signals:
//   flush           controller -> divider  abort any divide in progress
//   div_start       EX -> divider          DIV/DIVU held in EX
//   div_signed      EX -> divider          1 = DIV, 0 = DIVU
//   dividend        EX -> divider          dividend operand
//   divisor         EX -> divider          divisor operand
//   result_lo       divider -> EX          quotient
//   result_hi       divider -> EX          remainder
//   div_ready       divider -> EX          one-cycle result-valid pulse
//   stallreq_for_ex divider -> controller  hold the pipeline
interface ex_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_ready;
    logic             stallreq_for_ex;

    modport master (
        output flush, div_start, div_signed, dividend, divisor,
        input  result_lo, result_hi, div_ready, stallreq_for_ex
    );

    modport slave (
        input  flush, div_start, div_signed, dividend, divisor,
        output result_lo, result_hi, div_ready, stallreq_for_ex
    );
endinterface

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative radix-2 signed/unsigned divider for the EX stage
//
// Ports:
//   clk     clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     ex_div_unit_if.slave: operands/start/flush in, quotient/remainder/ready/stall out
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         resetn,
    ex_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_DBZ  = 2'd2,
        S_END  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] work;        // {partial remainder (WIDTH+1), quotient/dividend (WIDTH)}
    logic [WIDTH-1:0] divisor_abs;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_ready;
    logic             stallreq;

    logic [WIDTH-1:0] dividend_abs_in;
    logic [WIDTH-1:0] divisor_abs_in;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [2*WIDTH:0] work_step;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic             last_iter;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including a start in IDLE
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.div_start) state_nxt = (bus.divisor == '0) ? S_DBZ : S_ON;
                S_ON:   if (last_iter) state_nxt = S_END;
                S_DBZ:  state_nxt = S_END;
                S_END:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs; stall drops in END so the instruction leaves EX at the end of that cycle
    always_comb begin
        div_ready = (state == S_END);
        stallreq  = resetn && !bus.flush &&
                    (((state == S_IDLE) && bus.div_start) || (state == S_ON) || (state == S_DBZ));
    end

    assign bus.div_ready       = div_ready;
    assign bus.stallreq_for_ex = stallreq;
    assign bus.result_lo       = result_lo;
    assign bus.result_hi       = result_hi;

    // Magnitudes at start; signed 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign dividend_abs_in = (bus.div_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign divisor_abs_in  = (bus.div_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // One shift-subtract step; a bit shifted out of the top would mean the remainder already exceeds any divisor
    assign shifted   = {work[2*WIDTH-1:0], 1'b0};
    assign partial   = shifted[2*WIDTH:WIDTH];
    assign ge        = work[2*WIDTH] || (partial >= {1'b0, divisor_abs});
    assign diff      = partial - {1'b0, divisor_abs};
    assign work_step = ge ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted;
    assign q_mag     = work_step[WIDTH-1:0];
    assign r_mag     = work_step[2*WIDTH-1:WIDTH];
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Datapath and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            work        <= '0;
            divisor_abs <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.div_start) begin
                        cnt         <= '0;
                        divisor_abs <= divisor_abs_in;
                        q_neg       <= bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg       <= bus.div_signed & bus.dividend[WIDTH-1];
                        // Divide by zero returns the raw dividend, so keep it unmodified in that case
                        work        <= {{(WIDTH+1){1'b0}},
                                        (bus.divisor == '0) ? bus.dividend : dividend_abs_in};
                    end
                end
                S_ON: begin
                    work <= work_step;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        result_lo <= q_neg ? -q_mag : q_mag;
                        result_hi <= r_neg ? -r_mag : r_mag;
                    end
                end
                S_DBZ: begin
                    result_lo <= '1;
                    result_hi <= work[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - directed scoreboard bench for ex_div_unit
module tb_ex_div_unit;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    ex_div_unit_if #(.WIDTH(32)) dif ();

    ex_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (dif.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];              // expected {remainder, quotient}
    logic [31:0] held_lo  = '0;
    logic [31:0] held_hi  = '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference results from the language's own division operators
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sbv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa  = a;
        sbv = b;
        return {32'(sa % sbv), 32'(sa / sbv)};
    endfunction

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat);
        int          c;
        logic        stall_bad;
        logic [63:0] e;
        @(posedge clk);
        #1;
        dif.div_signed = sgn;
        dif.dividend   = a;
        dif.divisor    = b;
        dif.div_start  = 1'b1;
        sb.push_back(model(sgn, a, b));
        stall_bad = 1'b0;
        c = 0;
        @(negedge clk);
        while (!dif.div_ready && c < 40) begin
            if (dif.stallreq_for_ex !== 1'b1) stall_bad = 1'b1;
            c++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(c), 32'(exp_lat));
        check({tag, " stall_busy"}, {31'd0, stall_bad}, 32'd0);
        check({tag, " stall_end"}, {31'd0, dif.stallreq_for_ex}, 32'd0);
        e = sb.pop_front();
        check({tag, " quotient"}, dif.result_lo, e[31:0]);
        check({tag, " remainder"}, dif.result_hi, e[63:32]);
        held_lo = e[31:0];
        held_hi = e[63:32];
        @(posedge clk);
        #1;
        dif.div_start = 1'b0;
        @(negedge clk);
        check({tag, " ready_once"}, {31'd0, dif.div_ready}, 32'd0);
        check({tag, " idle_stall"}, {31'd0, dif.stallreq_for_ex}, 32'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        dif.flush      = 1'b0;
        dif.div_start  = 1'b0;
        dif.div_signed = 1'b0;
        dif.dividend   = '0;
        dif.divisor    = '0;
        #1;
        check("rst lo", dif.result_lo, 32'd0);
        check("rst hi", dif.result_hi, 32'd0);
        check("rst ready", {31'd0, dif.div_ready}, 32'd0);
        check("rst stall", {31'd0, dif.stallreq_for_ex}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        run_div("u100_7",   1'b0, 32'd100,       32'd7,         33);
        check("u100_7 q_const", held_lo, 32'd14);
        check("u100_7 r_const", held_hi, 32'd2);
        run_div("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         33);
        check("s_m7_2 q_const", held_lo, 32'hFFFF_FFFD);
        check("s_m7_2 r_const", held_hi, 32'hFFFF_FFFF);
        run_div("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2,         33);
        check("u_fff9_2 q_const", held_lo, 32'h7FFF_FFFC);
        run_div("dbz",      1'b1, 32'h1234_5678, 32'd0,         2);
        check("dbz r_const", held_hi, 32'h1234_5678);
        run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_div("s_pos_neg", 1'b1, 32'd1000,     32'hFFFF_FFFD, 33);
        for (int i = 0; i < 3; i++) begin
            run_div("rnd", 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom_range(1, 70000)), 33);
        end

        // Flush in cycle 10 of a divide
        @(posedge clk);
        #1;
        dif.div_signed = 1'b0;
        dif.dividend   = 32'h0000_1234;
        dif.divisor    = 32'd3;
        dif.div_start  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        dif.flush     = 1'b1;
        dif.div_start = 1'b0;
        #1;
        check("flush stall", {31'd0, dif.stallreq_for_ex}, 32'd0);
        @(posedge clk);
        #1;
        dif.flush = 1'b0;
        @(negedge clk);
        check("flush ready", {31'd0, dif.div_ready}, 32'd0);
        check("flush idle_stall", {31'd0, dif.stallreq_for_ex}, 32'd0);
        check("flush lo_held", dif.result_lo, held_lo);
        check("flush hi_held", dif.result_hi, held_hi);
        run_div("after_flush", 1'b0, 32'd1000, 32'd10, 33);
        check("after_flush q_const", held_lo, 32'd100);

        // Reset in cycle 15 of a divide, with div_start still high
        @(posedge clk);
        #1;
        dif.div_signed = 1'b0;
        dif.dividend   = 32'h0000_DEAD;
        dif.divisor    = 32'h11;
        dif.div_start  = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst lo", dif.result_lo, 32'd0);
        check("midrst hi", dif.result_hi, 32'd0);
        check("midrst ready", {31'd0, dif.div_ready}, 32'd0);
        check("midrst stall", {31'd0, dif.stallreq_for_ex}, 32'd0);
        @(posedge clk);
        #1;
        dif.div_start = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run_div("after_rst", 1'b0, 32'd50, 32'd5, 33);
        check("after_rst q_const", held_lo, 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
